// File: rtl/bolme_denetleyici.sv
// bolme_denetleyici: execute-stage front end for the iterative divider; BOLME_ONBELLEK_EN adds a 1-entry result cache
module bolme_denetleyici #(
    parameter int ZAMAN_ASIMI = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        gecerli_i,
    input  logic [1:0]  islem_i,
    input  logic [31:0] bolunen_i,
    input  logic [31:0] bolen_i,
    input  logic        temizle_i,
    output logic        durdur_o,
    output logic [31:0] sonuc_o,
    output logic        sonuc_gecerli_o,
    output logic        hata_o,
    output logic        bolme_basla_o,
    output logic [1:0]  bolme_islem_o,
    output logic [31:0] bolme_bolunen_o,
    output logic [31:0] bolme_bolen_o,
    input  logic [31:0] bolme_sonuc_i,
    input  logic        bolme_bitti_i
);
    localparam int SW = $clog2(ZAMAN_ASIMI + 1);
    typedef enum logic [1:0] {BOSTA, HESAPLA, SONUC} durum_t;
    durum_t      durum;
    logic [SW-1:0] sayac;
    logic        sifir_bolen, tasma, ozel, isabet, bitti_gec;
    logic [31:0] ozel_sonuc, isabet_sonuc;
    assign sifir_bolen = bolen_i == '0;
    assign tasma       = islem_i[1] && bolunen_i == 32'h8000_0000 && bolen_i == 32'hFFFF_FFFF;
    assign ozel        = sifir_bolen || tasma;
    assign ozel_sonuc  = sifir_bolen ? (islem_i[0] ? bolunen_i : 32'hFFFF_FFFF)
                                     : (islem_i[0] ? 32'h0 : 32'h8000_0000);
    assign bitti_gec   = durum == HESAPLA && bolme_bitti_i && sayac != '0;
    assign durdur_o    = gecerli_i && durum != SONUC && !temizle_i;
`ifdef BOLME_ONBELLEK_EN
    logic        on_gecerli;
    logic [1:0]  on_islem;
    logic [31:0] on_bolunen, on_bolen, on_sonuc;
    assign isabet = on_gecerli && on_islem == islem_i && on_bolunen == bolunen_i && on_bolen == bolen_i;
    assign isabet_sonuc = on_sonuc;
    // remember the last result the divider actually produced, keyed by the latched request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            on_gecerli <= 1'b0;
            on_islem   <= '0;
            on_bolunen <= '0;
            on_bolen   <= '0;
            on_sonuc   <= '0;
        end else if (bitti_gec && !temizle_i) begin
            on_gecerli <= 1'b1;
            on_islem   <= bolme_islem_o;
            on_bolunen <= bolme_bolunen_o;
            on_bolen   <= bolme_bolen_o;
            on_sonuc   <= bolme_sonuc_i;
        end
    end
`else
    assign isabet = 1'b0;
    assign isabet_sonuc = '0;
`endif
    // control FSM: accept, run the divider under a watchdog, present one result strobe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum           <= BOSTA;
            sayac           <= '0;
            sonuc_o         <= '0;
            sonuc_gecerli_o <= 1'b0;
            hata_o          <= 1'b0;
            bolme_basla_o   <= 1'b0;
            bolme_islem_o   <= '0;
            bolme_bolunen_o <= '0;
            bolme_bolen_o   <= '0;
        end else begin
            sonuc_gecerli_o <= 1'b0;
            bolme_basla_o   <= 1'b0;
            if (temizle_i) begin
                durum <= BOSTA;
            end else begin
                case (durum)
                    BOSTA: begin
                        if (gecerli_i) begin
                            bolme_islem_o   <= islem_i;
                            bolme_bolunen_o <= bolunen_i;
                            bolme_bolen_o   <= bolen_i;
                            if (ozel || isabet) begin
                                sonuc_o         <= ozel ? ozel_sonuc : isabet_sonuc;
                                sonuc_gecerli_o <= 1'b1;
                                durum           <= SONUC;
                            end else begin
                                sayac         <= '0;
                                bolme_basla_o <= 1'b1;
                                durum         <= HESAPLA;
                            end
                        end
                    end
                    HESAPLA: begin
                        sayac <= sayac + 1'b1;
                        if (bitti_gec) begin
                            sonuc_o         <= bolme_sonuc_i;
                            sonuc_gecerli_o <= 1'b1;
                            durum           <= SONUC;
                        end else if (sayac == SW'(ZAMAN_ASIMI - 1)) begin
                            hata_o          <= 1'b1;
                            sonuc_o         <= '0;
                            sonuc_gecerli_o <= 1'b1;
                            durum           <= SONUC;
                        end else begin
                            bolme_basla_o <= 1'b1;
                        end
                    end
                    default: durum <= BOSTA;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bolme_denetleyici.sv
// tb_bolme_denetleyici: randomized scoreboard bench with a behavioural divider and RV32M reference model
module tb_bolme_denetleyici;
    localparam int ZA = 32;
    logic        clk, rst, gecerli, temizle, bitti, hang;
    logic [1:0]  islem;
    logic [31:0] bolunen, bolen, dsonuc;
    logic        durdur, sonuc_gecerli, hata, basla;
    logic [31:0] sonuc, b_bolunen, b_bolen;
    logic [1:0]  b_islem;
    int cyc = 0, vectors = 0, miscompares = 0, dcnt = 0;
    typedef struct { logic [31:0] v; logic h; int c; } exp_t;
    exp_t q[$];
    logic        mhata = 0, c_ok = 0;
    logic [1:0]  c_op = 0;
    logic [31:0] c_a = 0, c_b = 0, c_v = 0, last_v = 0;

    bolme_denetleyici #(.ZAMAN_ASIMI(ZA)) dut (
        .clk_i(clk), .rst_i(rst), .gecerli_i(gecerli), .islem_i(islem),
        .bolunen_i(bolunen), .bolen_i(bolen), .temizle_i(temizle),
        .durdur_o(durdur), .sonuc_o(sonuc), .sonuc_gecerli_o(sonuc_gecerli),
        .hata_o(hata), .bolme_basla_o(basla), .bolme_islem_o(b_islem),
        .bolme_bolunen_o(b_bolunen), .bolme_bolen_o(b_bolen),
        .bolme_sonuc_i(dsonuc), .bolme_bitti_i(bitti));

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return op[0] ? a : 32'hFFFF_FFFF;
        if (op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'd0: return a / b;
            2'd1: return a % b;
            2'd2: return 32'($signed(a) / $signed(b));
            default: return 32'($signed(a) % $signed(b));
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // divider model: answers 18 cycles after its setup cycle, from the latched operands
    always @(negedge clk) begin
        if (basla) begin
            dcnt = dcnt + 1;
            bitti = !hang && dcnt == 19;
            if (bitti) dsonuc = ref_div(b_islem, b_bolunen, b_bolen);
        end else begin
            dcnt = 0;
            bitti = 0;
        end
    end

    // monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && sonuc_gecerli) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got %h want none", sonuc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sonuc", sonuc, e.v);
                chk("hata", {31'b0, hata}, {31'b0, e.h});
                chk("strobe_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int lat, dur;
        bit ozel, hit, yol, done, bas;
        ozel = b == 0 || (op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit = !ozel && c_ok && c_op == op && c_a == a && c_b == b;
        yol = !ozel && !hit;
        if (yol && hang) mhata = 1;
        e.v = (yol && hang) ? 32'h0 : hit ? c_v : ref_div(op, a, b);
        e.h = mhata;
        lat = !yol ? 1 : hang ? ZA + 1 : 20;
        e.c = cyc + lat;
        q.push_back(e);
        last_v = e.v;
        gecerli = 1; islem = op; bolunen = a; bolen = b;
        dur = 0; bas = 0; done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            #1;
            dur += int'(durdur);
            bas |= basla;
            @(negedge clk);
            done = sonuc_gecerli;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no strobe want strobe after %0d cycles", lat);
        end
        gecerli = 0;
        chk("durdur_cycles", 32'(dur), 32'(lat));
        chk("basla_seen", {31'b0, bas}, {31'b0, yol});
`ifdef BOLME_ONBELLEK_EN
        if (yol && !hang) begin
            c_ok = 1; c_op = op; c_a = a; c_b = b; c_v = e.v;
        end
`endif
        @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_sonuc", sonuc, 32'h0);
        chk("rst_strobe", {31'b0, sonuc_gecerli}, 32'h0);
        chk("rst_hata", {31'b0, hata}, 32'h0);
        chk("rst_basla", {31'b0, basla}, 32'h0);
        chk("rst_islem", {30'b0, b_islem}, 32'h0);
        chk("rst_bolunen", b_bolunen, 32'h0);
        chk("rst_bolen", b_bolen, 32'h0);
    endtask

    initial begin
        rst = 1; gecerli = 0; temizle = 0; islem = 0; bolunen = 0; bolen = 0;
        bitti = 0; hang = 0; dsonuc = 0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst = 0;
        @(negedge clk);
        do_req(2'd0, 100, 7);
        do_req(2'd1, 100, 7);
        do_req(2'd2, -32'sd7, 2);
        do_req(2'd3, -32'sd7, 2);
        do_req(2'd2, 7, -32'sd2);
        do_req(2'd2, 5, 0);
        do_req(2'd3, 5, 0);
        do_req(2'd0, 5, 0);
        do_req(2'd1, 5, 0);
        do_req(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_req(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        do_req(2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        // flush in the middle of a divide: divider released, no strobe, old result kept
        gecerli = 1; islem = 2'd0; bolunen = 1000; bolen = 3;
        repeat (5) @(negedge clk);
        temizle = 1; gecerli = 0;
        #1 chk("flush_durdur", {31'b0, durdur}, 32'h0);
        @(negedge clk);
        chk("flush_basla", {31'b0, basla}, 32'h0);
        chk("flush_sonuc", sonuc, last_v);
        temizle = 0;
        repeat (3) @(negedge clk);
        do_req(2'd0, 9, 3);
        // divider that never finishes trips the watchdog
        hang = 1;
        do_req(2'd0, 77, 5);
        hang = 0;
        do_req(2'd0, 50, 6);
        // reset in the middle of a divide
        gecerli = 1; islem = 2'd0; bolunen = 1234; bolen = 5;
        repeat (6) @(negedge clk);
        rst = 1; gecerli = 0;
        @(negedge clk);
        chk_reset_state();
        chk("rst_durdur", {31'b0, durdur}, 32'h0);
        rst = 0; mhata = 0; c_ok = 0; last_v = 0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [31:0] a, b;
            int sel;
            op = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            b = sel == 0 ? 32'h0 : sel == 1 ? 32'hFFFF_FFFF : sel == 2 ? 32'($urandom_range(1, 20)) : $urandom;
            a = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
            if ($urandom_range(0, 4) == 0) begin
                op = c_op; a = c_a; b = c_b;
            end
            do_req(op, a, b);
        end
        do_req(2'd0, 100, 7);
        do_req(2'd0, 100, 7);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
